rob_commit_unit: RTL and testbench

Reorder buffer for the out-of-order RISC-V core: allocates the ROB tags that the issue stage writes into reservation-station `Q` fields, and captures results broadcast by the ALU and the SLBuffer. It answers operand queries from issue and retires entries in program order. On a mispredicted branch it flushes the machine. Tag 0 means "value ready" throughout the core, so the ROB never hands out tag 0.

---
 rtl/rob_pkg.sv | 15 +
 rtl/rob_tag_inc.sv | 18 +
 rtl/rob_commit_unit.sv | 197 +++++++++++++++++++
 tb/tb_rob_commit_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared encodings and constants for the reorder buffer.
package rob_pkg;

    localparam int ROB_Q_WIDTH = 5;
    localparam int ROB_ENTRIES = (1 << ROB_Q_WIDTH) - 1;

    typedef logic [1:0] rob_type_t;

    localparam rob_type_t ROB_T_REG    = 2'd0;
    localparam rob_type_t ROB_T_STORE  = 2'd1;
    localparam rob_type_t ROB_T_BRANCH = 2'd2;

    localparam logic [ROB_Q_WIDTH-1:0] TAG_NONE = 5'd0;

endpackage

// File: rtl/rob_tag_inc.sv
// Wrap-around tag increment: the all-ones tag wraps to 1, never to TAG_NONE.
module rob_tag_inc #(
    parameter int W = 5
) (
    input  logic [W-1:0] tag,
    output logic [W-1:0] tag_next
);

    // next tag, skipping zero on wrap
    always_comb begin
        if (tag == {W{1'b1}}) begin
            tag_next = {{(W-1){1'b0}}, 1'b1};
        end else begin
            tag_next = tag + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// In-order retire reorder buffer with mispredict flush.
// Optional macro ROB_QUERY_BYPASS_EN: operand queries also see same-cycle broadcasts.
module rob_commit_unit
    import rob_pkg::*;
#(
    parameter int Q_WIDTH        = 5,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      issue_valid,
    input  logic [1:0]                issue_type,
    input  logic [REG_ADDR_WIDTH-1:0] issue_dest,
    input  logic                      issue_pred_taken,
    input  logic [31:0]               issue_npc,
    output logic [Q_WIDTH-1:0]        alloc_tag,
    output logic                      ROB_Full,
    input  logic [Q_WIDTH-1:0]        query_tag1,
    input  logic [Q_WIDTH-1:0]        query_tag2,
    output logic                      query_ready1,
    output logic                      query_ready2,
    output logic [31:0]               query_value1,
    output logic [31:0]               query_value2,
    input  logic                      update_control,
    input  logic [Q_WIDTH-1:0]        target_ROB_pos,
    input  logic [31:0]               V_ex,
    input  logic                      ex_taken,
    input  logic [31:0]               ex_target_pc,
    input  logic                      has_slb_result,
    input  logic [Q_WIDTH-1:0]        slb_target_ROB_pos,
    input  logic [31:0]               V_slb,
    output logic                      commit_valid,
    output logic [Q_WIDTH-1:0]        commit_tag,
    output logic [REG_ADDR_WIDTH-1:0] commit_dest,
    output logic [31:0]               commit_value,
    output logic                      commit_store,
    output logic                      flush,
    output logic [31:0]               flush_pc
);

    localparam int DEPTH = 1 << Q_WIDTH;
    localparam logic [Q_WIDTH-1:0] TAG_ONE   = {{(Q_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [Q_WIDTH-1:0] MAX_COUNT = {Q_WIDTH{1'b1}};

    logic                      busy_r    [DEPTH];
    logic                      ready_r   [DEPTH];
    rob_type_t                 type_r    [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] dest_r    [DEPTH];
    logic [31:0]               value_r   [DEPTH];
    logic                      pred_r    [DEPTH];
    logic                      mispred_r [DEPTH];
    logic [31:0]               npc_r     [DEPTH];
    logic [31:0]               redir_r   [DEPTH];

    logic [Q_WIDTH-1:0]        head_r, tail_r, count_r;
    logic [Q_WIDTH-1:0]        head_next_s, tail_next_s, count_next_s;
    logic                      full_r;
    logic                      issue_ok_s, commit_s, flush_s;
    logic                      commit_valid_r, commit_store_r, flush_r;
    logic [Q_WIDTH-1:0]        commit_tag_r;
    logic [REG_ADDR_WIDTH-1:0] commit_dest_r;
    logic [31:0]               commit_value_r, flush_pc_r;

    rob_tag_inc #(.W(Q_WIDTH)) u_head_inc (.tag(head_r), .tag_next(head_next_s));
    rob_tag_inc #(.W(Q_WIDTH)) u_tail_inc (.tag(tail_r), .tag_next(tail_next_s));

    assign issue_ok_s = issue_valid && !full_r;
    assign commit_s   = busy_r[head_r] && ready_r[head_r];
    assign flush_s    = commit_s && (type_r[head_r] == ROB_T_BRANCH) && mispred_r[head_r];

    assign alloc_tag    = tail_r;
    assign ROB_Full     = full_r;
    assign commit_valid = commit_valid_r;
    assign commit_store = commit_store_r;
    assign commit_tag   = commit_tag_r;
    assign commit_dest  = commit_dest_r;
    assign commit_value = commit_value_r;
    assign flush        = flush_r;
    assign flush_pc     = flush_pc_r;

    // {ready, value} for one operand tag; tag 0 is never "ready" here
    function automatic logic [32:0] query_lookup(input logic [Q_WIDTH-1:0] tag);
        logic [32:0] res;
        res = {1'b0, 32'd0};
        if (tag == TAG_NONE) begin
            res = {1'b0, 32'd0};
`ifdef ROB_QUERY_BYPASS_EN
        end else if (update_control && (target_ROB_pos == tag)) begin
            res = {1'b1, V_ex};
        end else if (has_slb_result && (slb_target_ROB_pos == tag)) begin
            res = {1'b1, V_slb};
`endif
        end else if (busy_r[tag] && ready_r[tag]) begin
            res = {1'b1, value_r[tag]};
        end else begin
            res = {1'b0, 32'd0};
        end
        return res;
    endfunction

    // operand query ports
    always_comb begin
        {query_ready1, query_value1} = query_lookup(query_tag1);
        {query_ready2, query_value2} = query_lookup(query_tag2);
    end

    // occupancy after this edge's issue/commit pair
    always_comb begin
        count_next_s = count_r;
        case ({issue_ok_s, commit_s})
            2'b10:   count_next_s = count_r + TAG_ONE;
            2'b01:   count_next_s = count_r - TAG_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // entry state, pointers and registered retire/flush pulses
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_r         <= TAG_ONE;
            tail_r         <= TAG_ONE;
            count_r        <= '0;
            full_r         <= 1'b0;
            commit_valid_r <= 1'b0;
            commit_store_r <= 1'b0;
            flush_r        <= 1'b0;
            commit_tag_r   <= '0;
            commit_dest_r  <= '0;
            commit_value_r <= 32'd0;
            flush_pc_r     <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                busy_r[i]    <= 1'b0;
                ready_r[i]   <= 1'b0;
                mispred_r[i] <= 1'b0;
            end
        end else if (!rdy_in) begin
            commit_valid_r <= 1'b0;
            commit_store_r <= 1'b0;
            flush_r        <= 1'b0;
        end else begin
            commit_valid_r <= commit_s;
            commit_store_r <= commit_s && (type_r[head_r] == ROB_T_STORE);
            flush_r        <= flush_s;
            if (commit_s) begin
                commit_tag_r   <= head_r;
                commit_dest_r  <= dest_r[head_r];
                commit_value_r <= value_r[head_r];
            end
            if (flush_s) begin
                // mispredict: everything younger is squashed, same-edge traffic dropped
                flush_pc_r <= redir_r[head_r];
                head_r     <= TAG_ONE;
                tail_r     <= TAG_ONE;
                count_r    <= '0;
                full_r     <= 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    busy_r[i]  <= 1'b0;
                    ready_r[i] <= 1'b0;
                end
            end else begin
                if (has_slb_result && (slb_target_ROB_pos != TAG_NONE) && busy_r[slb_target_ROB_pos]) begin
                    ready_r[slb_target_ROB_pos] <= 1'b1;
                    value_r[slb_target_ROB_pos] <= V_slb;
                end
                // ALU write placed last so it overrides an equal-tag SLB write
                if (update_control && (target_ROB_pos != TAG_NONE) && busy_r[target_ROB_pos]) begin
                    ready_r[target_ROB_pos] <= 1'b1;
                    value_r[target_ROB_pos] <= V_ex;
                    if (type_r[target_ROB_pos] == ROB_T_BRANCH) begin
                        mispred_r[target_ROB_pos] <= (ex_taken != pred_r[target_ROB_pos]);
                        redir_r[target_ROB_pos]   <= ex_taken ? ex_target_pc : npc_r[target_ROB_pos];
                    end
                end
                if (commit_s) begin
                    busy_r[head_r]  <= 1'b0;
                    ready_r[head_r] <= 1'b0;
                    head_r          <= head_next_s;
                end
                if (issue_ok_s) begin
                    busy_r[tail_r]    <= 1'b1;
                    ready_r[tail_r]   <= 1'b0;
                    mispred_r[tail_r] <= 1'b0;
                    type_r[tail_r]    <= issue_type;
                    dest_r[tail_r]    <= issue_dest;
                    pred_r[tail_r]    <= issue_pred_taken;
                    npc_r[tail_r]     <= issue_npc;
                    redir_r[tail_r]   <= issue_npc;
                    tail_r            <= tail_next_s;
                end
                count_r <= count_next_s;
                full_r  <= (count_next_s == MAX_COUNT);
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Scoreboard bench for rob_commit_unit: expected retires queued at issue, checked at commit.
module tb_rob_commit_unit;
    import rob_pkg::*;

`ifdef ROB_QUERY_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        issue_valid, issue_pred_taken;
    logic [1:0]  issue_type;
    logic [4:0]  issue_dest, alloc_tag;
    logic [31:0] issue_npc;
    logic        ROB_Full;
    logic [4:0]  query_tag1, query_tag2;
    logic        query_ready1, query_ready2;
    logic [31:0] query_value1, query_value2;
    logic        update_control, ex_taken, has_slb_result;
    logic [4:0]  target_ROB_pos, slb_target_ROB_pos;
    logic [31:0] V_ex, ex_target_pc, V_slb;
    logic        commit_valid, commit_store, flush;
    logic [4:0]  commit_tag, commit_dest;
    logic [31:0] commit_value, flush_pc;

    always #5 clk_in = ~clk_in;

    rob_commit_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_dest(issue_dest),
        .issue_pred_taken(issue_pred_taken), .issue_npc(issue_npc),
        .alloc_tag(alloc_tag), .ROB_Full(ROB_Full),
        .query_tag1(query_tag1), .query_tag2(query_tag2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_value1(query_value1), .query_value2(query_value2),
        .update_control(update_control), .target_ROB_pos(target_ROB_pos), .V_ex(V_ex),
        .ex_taken(ex_taken), .ex_target_pc(ex_target_pc),
        .has_slb_result(has_slb_result), .slb_target_ROB_pos(slb_target_ROB_pos), .V_slb(V_slb),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_dest(commit_dest),
        .commit_value(commit_value), .commit_store(commit_store),
        .flush(flush), .flush_pc(flush_pc)
    );

    typedef struct packed {
        logic [4:0]  tag;
        logic [4:0]  dest;
        logic [31:0] value;
        logic        store;
        logic        flush;
        logic [31:0] fpc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] plan_val [32];
    logic [4:0]  exp_tail;
    int          chk_cnt  = 0;
    int          pass_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] tag_inc(input logic [4:0] t);
        return (t == 5'd31) ? 5'd1 : t + 5'd1;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        issue_valid    = 1'b0;
        update_control = 1'b0;
        has_slb_result = 1'b0;
        ex_taken       = 1'b0;
    endtask

    // drive one allocation; the planned result is what the bench will broadcast later
    task automatic issue(input logic [1:0] ty, input logic [4:0] dest, input logic pred,
                         input logic [31:0] val, input logic expect_commit,
                         input logic exp_flush, input logic [31:0] fpc);
        exp_t e;
        check_eq("alloc_tag", alloc_tag, exp_tail);
        issue_valid      = 1'b1;
        issue_type       = ty;
        issue_dest       = dest;
        issue_pred_taken = pred;
        issue_npc        = val;
        plan_val[exp_tail] = val;
        if (expect_commit) begin
            e.tag = exp_tail; e.dest = dest; e.value = val;
            e.store = (ty == ROB_T_STORE); e.flush = exp_flush; e.fpc = fpc;
            exp_q.push_back(e);
        end
        exp_tail = tag_inc(exp_tail);
    endtask

    task automatic alu(input logic [4:0] t);
        update_control = 1'b1;
        target_ROB_pos = t;
        V_ex           = plan_val[t];
    endtask

    task automatic slb(input logic [4:0] t);
        has_slb_result     = 1'b1;
        slb_target_ROB_pos = t;
        V_slb              = plan_val[t];
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check_eq("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // retire monitor
    always @(negedge clk_in) begin
        if (commit_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_commit", {59'd0, commit_tag}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("commit_tag", commit_tag, mon_e.tag);
                check_eq("commit_value", commit_value, mon_e.value);
                check_eq("commit_store", commit_store, mon_e.store);
                check_eq("flush", flush, mon_e.flush);
                if (!mon_e.store) check_eq("commit_dest", commit_dest, mon_e.dest);
                if (mon_e.flush) check_eq("flush_pc", flush_pc, mon_e.fpc);
            end
        end else if (flush || commit_store) begin
            check_eq("pulse_without_commit", {62'd0, flush, commit_store}, 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] cur, h;
        rst_in = 1'b0; rdy_in = 1'b1;
        issue_type = ROB_T_REG; issue_dest = 5'd0; issue_pred_taken = 1'b0; issue_npc = 32'd0;
        query_tag1 = 5'd0; query_tag2 = 5'd0;
        target_ROB_pos = 5'd0; V_ex = 32'd0; ex_target_pc = 32'd0;
        slb_target_ROB_pos = 5'd0; V_slb = 32'd0;
        idle();
        step(); step();
        check_eq("rst_alloc_tag", alloc_tag, 5'd1);
        check_eq("rst_full", ROB_Full, 1'b0);
        check_eq("rst_pulses", {commit_valid, commit_store, flush}, 3'd0);
        check_eq("rst_commit_tag", commit_tag, 5'd0);
        check_eq("rst_flush_pc", flush_pc, 32'd0);
        rst_in = 1'b1;
        exp_tail = 5'd1;

        // wrap: 40 back-to-back ops, each result broadcast the cycle after issue
        cur = 5'd0;
        for (int i = 0; i < 40; i++) begin
            h = exp_tail;
            issue((i % 7 == 3) ? ROB_T_STORE : ROB_T_REG, 5'(i % 31 + 1), 1'b0, 32'h1000 + i, 1'b1, 1'b0, 32'd0);
            if (i > 0) begin
                if (i % 2 == 1) alu(cur); else slb(cur);
            end
            cur = h;
            step(); idle();
        end
        alu(cur); step(); idle();
        wait_drain();

        // full: 31 outstanding, extra issues dropped even on a commit edge
        for (int i = 0; i < 31; i++) begin
            issue(ROB_T_REG, 5'd3, 1'b0, 32'h2000 + i, 1'b1, 1'b0, 32'd0);
            step(); idle();
        end
        check_eq("full_set", ROB_Full, 1'b1);
        issue_valid = 1'b1; step(); idle();
        check_eq("drop_full_tag", alloc_tag, exp_tail);
        check_eq("full_hold", ROB_Full, 1'b1);
        h = exp_tail;
        alu(h); step(); idle();
        check_eq("full_before_commit", ROB_Full, 1'b1);
        issue_valid = 1'b1; step(); idle();
        check_eq("full_cleared", ROB_Full, 1'b0);
        check_eq("drop_on_commit_tag", alloc_tag, exp_tail);
        h = tag_inc(h);
        for (int i = 0; i < 30; i++) begin
            if (i == 5) begin
                alu(h); has_slb_result = 1'b1; slb_target_ROB_pos = h; V_slb = 32'hDEAD;
            end else if (i % 2 == 0) begin
                alu(h);
            end else begin
                slb(h);
            end
            step(); idle();
            h = tag_inc(h);
        end
        wait_drain();

        // reset with ops in flight: nothing retires afterwards
        issue(ROB_T_REG, 5'd1, 1'b0, 32'h55, 1'b0, 1'b0, 32'd0); cur = alloc_tag; step(); idle();
        issue(ROB_T_REG, 5'd2, 1'b0, 32'h66, 1'b0, 1'b0, 32'd0); step(); idle();
        alu(cur); step(); idle();
        rst_in = 1'b0; step(); rst_in = 1'b1;
        exp_tail = 5'd1;
        check_eq("mid_rst_alloc_tag", alloc_tag, 5'd1);
        check_eq("mid_rst_full", ROB_Full, 1'b0);
        check_eq("mid_rst_pulses", {commit_valid, flush}, 2'd0);
        step(); step();

        // out-of-order results retire in order on consecutive cycles
        issue(ROB_T_REG, 5'd4, 1'b0, 32'h11, 1'b1, 1'b0, 32'd0); step(); idle();
        issue(ROB_T_REG, 5'd5, 1'b0, 32'h22, 1'b1, 1'b0, 32'd0); step(); idle();
        issue(ROB_T_REG, 5'd6, 1'b0, 32'h33, 1'b1, 1'b0, 32'd0); step(); idle();
        alu(5'd3); step(); idle();
        alu(5'd2); step(); idle();
        alu(5'd1); step(); idle();
        step(); step(); step();
        @(negedge clk_in); #1;
        check_eq("ooo_consecutive", 64'(exp_q.size()), 64'd0);
        rst_in = 1'b0; step(); rst_in = 1'b1;
        exp_tail = 5'd1;

        // mispredict: correct branch at 1, wrong branch at 2, younger 3..5 squashed
        issue(ROB_T_BRANCH, 5'd1, 1'b1, 32'h104, 1'b1, 1'b0, 32'd0); step(); idle();
        issue(ROB_T_BRANCH, 5'd1, 1'b0, 32'h204, 1'b1, 1'b1, 32'h1000); step(); idle();
        for (int i = 0; i < 3; i++) begin
            issue(ROB_T_REG, 5'(i + 8), 1'b0, 32'h300 + i, 1'b0, 1'b0, 32'd0); step(); idle();
        end
        alu(5'd1); ex_taken = 1'b1; ex_target_pc = 32'h500; step(); idle();
        alu(5'd2); ex_taken = 1'b1; ex_target_pc = 32'h1000; step(); idle();
        issue_valid = 1'b1; alu(5'd3); step(); idle();
        exp_tail = 5'd1;
        check_eq("flush_alloc_tag", alloc_tag, 5'd1);
        check_eq("flush_full", ROB_Full, 1'b0);
        alu(5'd4); step(); idle();
        issue(ROB_T_REG, 5'd9, 1'b0, 32'h77, 1'b1, 1'b0, 32'd0); step(); idle();
        alu(5'd1); step(); idle();
        wait_drain();

        // query bypass, then a stall that holds a ready head
        cur = exp_tail;
        issue(ROB_T_REG, 5'd7, 1'b0, 32'hABCD, 1'b1, 1'b0, 32'd0); step(); idle();
        query_tag1 = cur; query_tag2 = 5'd0;
        alu(cur); #1;
        check_eq("bypass_ready", query_ready1, BYP);
        check_eq("bypass_value", query_value1, BYP ? 32'hABCD : 32'd0);
        check_eq("query_tag0", query_ready2, 1'b0);
        step(); idle();
        rdy_in = 1'b0; #1;
        check_eq("query_ready_reg", query_ready1, 1'b1);
        check_eq("query_value_reg", query_value1, 32'hABCD);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_no_commit", commit_valid, 1'b0);
        end
        rdy_in = 1'b1;
        step();
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
